sale_req: RTL and testbench

SALE_REQ -- requirements
Module: sale_req

---
 rtl/sale_req_if.sv | 31 +++
 rtl/sale_req.sv | 117 +++++++++++
 tb/tb_sale_req.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sale_req_if.sv
// ============================================================================
// Module   : sale_req_if
// Purpose  : Purchase handshake bundle between the host/sequencer and sale_req.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sale_req_if;
  logic       req;
  logic       pay;
  logic [3:0] sl;
  logic [1:0] slif;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] txn_cnt;

  // Environment side: host request/payment plus sequencer step pulses
  modport master (
    output req, pay, sl,
    input  slif, busy, done, err, txn_cnt
  );

  // Controller side
  modport slave (
    input  req, pay, sl,
    output slif, busy, done, err, txn_cnt
  );
endinterface

`default_nettype wire

// File: rtl/sale_req.sv
// ============================================================================
// Module   : sale_req
// Purpose  : Sale transaction controller; walks the sequencer through
//            start/pay/step2/step3 with timeouts and a completed-txn counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sale_req #(
  parameter logic [7:0] TMO = 8'd15
) (
  input  wire logic   clk,
  input  wire logic   rset,
  sale_req_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    PAY   = 3'd2,
    ACK1  = 3'd3,
    WAIT2 = 3'd4,
    WAIT3 = 3'd5
  } state_t;

  // Counter value at the edge that completes the TMO-th waiting cycle
  localparam logic [7:0] TMO_LAST = TMO - 8'd1;

  state_t     state;
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state       <= IDLE;
      tmo_cnt     <= 8'h00;
      bus.slif    <= 2'b00;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.txn_cnt <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state    <= REQ;
            tmo_cnt  <= 8'h00;
            bus.slif <= 2'b01;
            bus.busy <= 1'b1;
          end
        end
        REQ: begin
          if (bus.sl[0]) begin
            state    <= PAY;
            bus.slif <= 2'b00;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= IDLE;
            bus.slif <= 2'b00;
            bus.busy <= 1'b0;
            bus.err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        PAY: begin
          // Payment may take arbitrarily long; no timeout here
          if (bus.pay) begin
            state    <= ACK1;
            tmo_cnt  <= 8'h00;
            bus.slif <= 2'b10;
          end
        end
        ACK1: begin
          if (bus.sl[1]) begin
            state    <= WAIT2;
            bus.slif <= 2'b00;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= IDLE;
            bus.slif <= 2'b00;
            bus.busy <= 1'b0;
            bus.err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT2: begin
          if (bus.sl[2]) begin
            state <= WAIT3;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.err  <= 1'b1;
          end
        end
        WAIT3: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (bus.sl[3]) begin
            bus.done    <= 1'b1;
            bus.txn_cnt <= bus.txn_cnt + 8'd1;
          end else begin
            bus.err <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.slif <= 2'b00;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sale_req.sv
// ============================================================================
// Module   : tb_sale_req
// Purpose  : Directed self-checking bench for sale_req (TMO = 3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sale_req;

  logic clk  = 1'b0;
  logic rset = 1'b1;
  always #5 clk = ~clk;

  sale_req_if bus ();

  sale_req #(.TMO(8'd3)) dut (
    .clk  (clk),
    .rset (rset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_cnt = 8'h00;

  // Compliant-sequencer stimulus and expected outputs, indexed by edge E0..E7
  logic [3:0] sl_tab   [8];
  logic [1:0] slif_tab [8];
  logic       busy_tab [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req = 1'b0; bus.pay = 1'b0; bus.sl = 4'h0;
    #2 rset = 1'b0;
    #1;
    vectors++;
    if (bus.slif !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0 || bus.txn_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: slif=%b busy=%b done=%b err=%b cnt=%h, required 00 0 0 0 00",
               bus.slif, bus.busy, bus.done, bus.err, bus.txn_cnt);
    end
    tick; tick;
    rset = 1'b1;
    tick;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_nominal;
    for (int k = 0; k < 8; k++) begin
      bus.req = (k == 0);
      bus.pay = 1'b1;
      bus.sl  = sl_tab[k];
      tick;
      if (k == 7) exp_cnt++;
      vectors++;
      if (bus.slif !== slif_tab[k] || bus.busy !== busy_tab[k] ||
          bus.done !== (k == 7) || bus.err !== 1'b0 || bus.txn_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL nominal E%0d: slif=%b busy=%b done=%b err=%b cnt=%h, required %b %b %b 0 %h",
                 k, bus.slif, bus.busy, bus.done, bus.err, bus.txn_cnt,
                 slif_tab[k], busy_tab[k], (k == 7), exp_cnt);
      end
    end
    bus.sl = 4'h0;
    tick;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_after: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_start_timeout;
    bus.req = 1'b1; bus.pay = 1'b1; bus.sl = 4'h0;
    tick;
    bus.req = 1'b0;
    bus.sl  = 4'b1110;  // stray steps must not advance REQ
    for (int k = 1; k <= 2; k++) begin
      tick;
      vectors++;
      if (bus.slif !== 2'b01 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL start_wait E%0d: slif=%b err=%b busy=%b, required 01 0 1",
                 k, bus.slif, bus.err, bus.busy);
      end
    end
    tick;
    vectors++;
    if (bus.slif !== 2'b00 || bus.err !== 1'b1 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.txn_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL start_timeout: slif=%b err=%b busy=%b done=%b cnt=%h, required 00 1 0 0 %h",
               bus.slif, bus.err, bus.busy, bus.done, bus.txn_cnt, exp_cnt);
    end
    bus.sl = 4'h0;
    tick;
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL start_timeout_pulse: err=%b, required 0", bus.err);
    end
  endtask

  task automatic test_ack_timeout;
    for (int k = 0; k < 4; k++) begin
      bus.req = (k == 0); bus.pay = 1'b1; bus.sl = sl_tab[k];
      tick;
    end
    bus.sl = 4'b1101;  // everything but the expected sl[1]
    for (int k = 4; k <= 5; k++) begin
      tick;
      vectors++;
      if (bus.slif !== 2'b10 || bus.err !== 1'b0) begin
        miscompares++;
        $display("FAIL ack_wait E%0d: slif=%b err=%b, required 10 0", k, bus.slif, bus.err);
      end
    end
    tick;
    vectors++;
    if (bus.slif !== 2'b00 || bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.txn_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL ack_timeout: slif=%b err=%b busy=%b cnt=%h, required 00 1 0 %h",
               bus.slif, bus.err, bus.busy, bus.txn_cnt, exp_cnt);
    end
    bus.sl = 4'h0;
    tick;
  endtask

  task automatic test_pay_stall;
    int bad = 0;
    bus.pay = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req = (k == 0); bus.sl = sl_tab[k];
      tick;
    end
    bus.sl  = 4'h0;
    bus.req = 1'b1;  // requests while busy are dropped
    for (int k = 0; k < 50; k++) begin
      tick;
      if (bus.busy !== 1'b1 || bus.slif !== 2'b00 || bus.err !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL pay_stall: %0d bad cycles, required 0", bad);
    end
    bus.req = 1'b0;
    bus.pay = 1'b1;
    tick;
    vectors++;
    if (bus.slif !== 2'b10) begin
      miscompares++;
      $display("FAIL pay_release: slif=%b, required 10", bus.slif);
    end
    for (int k = 4; k < 8; k++) begin
      bus.sl = sl_tab[k];
      tick;
    end
    exp_cnt++;
    vectors++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.txn_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL pay_done: done=%b err=%b cnt=%h, required 1 0 %h",
               bus.done, bus.err, bus.txn_cnt, exp_cnt);
    end
    bus.sl = 4'h0;
    tick;
    vectors++;
    if (bus.busy !== 1'b0 || bus.slif !== 2'b00) begin
      miscompares++;
      $display("FAIL no_queue: busy=%b slif=%b, required 0 00", bus.busy, bus.slif);
    end
  endtask

  task automatic test_protocol_err;
    for (int k = 0; k < 6; k++) begin
      bus.req = (k == 0); bus.pay = 1'b1; bus.sl = sl_tab[k];
      tick;
    end
    bus.sl = 4'b1000;  // step 3 early instead of step 2
    tick;
    vectors++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.txn_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL protocol_err: err=%b done=%b busy=%b cnt=%h, required 1 0 0 %h",
               bus.err, bus.done, bus.busy, bus.txn_cnt, exp_cnt);
    end
    bus.sl = 4'h0;
    tick;
    vectors++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL protocol_err_after: err=%b busy=%b, required 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    int errs  = 0;
    rset = 1'b0;
    tick;
    rset = 1'b1;
    exp_cnt = 8'h00;
    for (int t = 0; t < 256; t++) begin
      for (int k = 0; k < 8; k++) begin
        bus.req = (k == 0); bus.pay = 1'b1; bus.sl = sl_tab[k];
        tick;
        if (bus.done === 1'b1) dones++;
        if (bus.err === 1'b1) errs++;
      end
      if (t == 254) begin
        vectors++;
        if (bus.txn_cnt !== 8'hFF) begin
          miscompares++;
          $display("FAIL wrap_ff: cnt=%h, required ff", bus.txn_cnt);
        end
      end
    end
    bus.sl = 4'h0;
    vectors++;
    if (bus.txn_cnt !== 8'h00 || dones != 256 || errs != 0) begin
      miscompares++;
      $display("FAIL wrap: cnt=%h dones=%0d errs=%0d, required 00 256 0",
               bus.txn_cnt, dones, errs);
    end
  endtask

  task automatic test_async_reset;
    int bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.req = (k == 0); bus.pay = 1'b1; bus.sl = sl_tab[k];
      tick;
    end
    vectors++;
    if (bus.slif !== 2'b10) begin
      miscompares++;
      $display("FAIL async_setup: slif=%b, required 10", bus.slif);
    end
    #2 rset = 1'b0;
    #1;
    vectors++;
    if (bus.slif !== 2'b00 || bus.busy !== 1'b0 || bus.txn_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: slif=%b busy=%b cnt=%h, required 00 0 00",
               bus.slif, bus.busy, bus.txn_cnt);
    end
    tick; tick;
    rset = 1'b1;
    for (int k = 5; k < 8; k++) begin
      bus.sl = sl_tab[k];
      tick;
      if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    bus.sl = 4'h0;
    tick;
    vectors++;
    if (bad != 0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_after: %0d bad cycles, required 0", bad);
    end
  endtask

  initial begin
    sl_tab   = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8};
    slif_tab = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    busy_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    test_reset;
    test_nominal;
    test_start_timeout;
    test_ack_timeout;
    test_pay_stall;
    test_protocol_err;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
